// File: rtl/fetch_redirect_ctrl.sv
// Next-PC sequencing for the IF stage: exception/ERET entry, branch redirect
// (held across stalls), sequential fetch and end-of-program halt detection.
module fetch_redirect_ctrl #(
    parameter logic [31:0] TEXT_START  = 32'h0000_3000,
    parameter logic [31:0] KTEXT_START = 32'h0000_4180,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             exc_entry,
    input  logic             eret,
    input  logic [29:0]      epc,
    input  logic             br_taken,
    input  logic [31:0]      br_target,
    input  logic [31:0]      pc_cur,
    output logic [31:0]      npc,
    output logic             pc_en,
    output logic             clr_ifid,
    output logic             halted,
    output logic             redir_pending,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        PEND = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [31:0] HALT_PC = KTEXT_START - 32'd4;

    state_t            r_state;
    state_t            w_next;
    logic [31:0]       r_pend_tgt;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic              w_cp0_evt;
    logic              w_pend_load;
    logic              w_at_halt_pc;

    assign w_cp0_evt    = exc_entry | eret;
    assign w_at_halt_pc = (pc_cur == HALT_PC);
    assign w_pend_load  = (r_state == RUN) && !w_cp0_evt && br_taken && stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (w_cp0_evt) begin
            w_next = RUN;
        end else begin
            unique case (r_state)
                RUN: begin
                    if (br_taken) begin
                        if (stall) w_next = PEND;
                    end else if (w_at_halt_pc) begin
                        w_next = HALT;
                    end
                end
                PEND:    if (!stall) w_next = RUN;
                HALT:    w_next = HALT;
                default: w_next = RUN;
            endcase
        end
    end

    // Outputs are forced to the reset image combinationally so they follow an
    // asynchronous reset assertion without waiting for a clock edge.
    always_comb begin
        npc           = pc_cur;
        pc_en         = 1'b0;
        clr_ifid      = 1'b0;
        halted        = (r_state == HALT);
        redir_pending = (r_state == PEND);
        if (!reset) begin
            npc           = TEXT_START;
            clr_ifid      = 1'b1;
            halted        = 1'b0;
            redir_pending = 1'b0;
        end else if (exc_entry) begin
            npc      = KTEXT_START;
            pc_en    = 1'b1;
            clr_ifid = 1'b1;
        end else if (eret) begin
            npc      = {epc, 2'b00};
            pc_en    = 1'b1;
            clr_ifid = 1'b1;
        end else begin
            unique case (r_state)
                RUN: begin
                    if (br_taken) begin
                        if (!stall) begin
                            npc   = br_target;
                            pc_en = 1'b1;
                        end
                    end else if (!w_at_halt_pc && !stall) begin
                        npc   = pc_cur + 32'd4;
                        pc_en = 1'b1;
                    end
                end
                PEND: begin
                    if (!stall) begin
                        npc   = r_pend_tgt;
                        pc_en = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend_tgt <= '0;
        end else if (w_pend_load) begin
            r_pend_tgt <= br_target;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (!pc_en && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule

// File: doc/fetch_redirect_ctrl.md
Name: fetch_redirect_ctrl

Overview:
Sequencing controller for the IF-stage PC register. It picks the next-PC source each cycle: exception entry, ERET, taken branch/jump, or sequential PC+4. It holds a branch redirect that arrives while the pipeline stalls, and detects the end-of-program halt address. It drives the PC write enable, the NPC value and the IF/ID flush, sitting between the hazard unit, CP0, the ID-stage branch comparator and the PC register.

Parameters:
TEXT_START, 32'h0000_3000, PC reset value / user text base
KTEXT_START, 32'h0000_4180, exception handler entry address
CNT_W, 16, width of the saturating stall-cycle counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = in reset)
stall  in  1  hazard-unit stall; PC must hold unless overridden
exc_entry  in  1  CP0 exception/interrupt entry request (single-cycle)
eret  in  1  CP0 ERET request (single-cycle)
epc  in  30  CP0 EPC[31:2]
br_taken  in  1  ID-stage branch taken or jump (J/JAL/JR/JALR) resolved
br_target  in  32  ID-stage computed target
pc_cur  in  32  current PC register value
npc  out  32  next PC for the PC register
pc_en  out  1  PC write enable
clr_ifid  out  1  flush IF/ID register this cycle
halted  out  1  fetch halted at KTEXT_START-4
redir_pending  out  1  a stalled branch redirect is held
stall_cnt  out  CNT_W  saturating count of cycles with pc_en=0 outside reset

Behaviour:
- States: RUN, PEND, HALT. Reset (reset=0, async) forces RUN, pend_tgt=0, stall_cnt=0.
- While reset=0, outputs are forced: npc=TEXT_START, pc_en=0, clr_ifid=1, halted=0, redir_pending=0.
- Source priority, evaluated combinationally every cycle: exc_entry > eret > branch (live br_taken or held pend_tgt) > halt > sequential.
- exc_entry=1, any state: npc=KTEXT_START, pc_en=1 (overrides stall), clr_ifid=1. Next state RUN, pending redirect discarded.
- eret=1 and exc_entry=0, any state: npc={epc,2'b00}, pc_en=1 (overrides stall), clr_ifid=1, next RUN, pending discarded. No delay slot is executed after ERET.
- RUN, br_taken=1, stall=0: npc=br_target, pc_en=1, clr_ifid=0. The delay slot is already in IF and must not be flushed.
- RUN, br_taken=1, stall=1: pc_en=0, pend_tgt<=br_target, next PEND.
- PEND, stall=1: pc_en=0, pend_tgt is not reloaded.
- PEND, stall=0: npc=pend_tgt, pc_en=1, next RUN. A br_taken still asserted in that cycle is the same instruction and is ignored.
- RUN, no redirect, stall=0: npc=pc_cur+4 (32-bit wrap), pc_en=1.
- Halt detect: in RUN with no higher-priority event, pc_cur==KTEXT_START-4 gives next HALT, pc_en=0.
- HALT: halted=1, npc=pc_cur, pc_en=0. Only exc_entry, eret or reset leave HALT.
- Any stall=1 without exc_entry/eret: pc_en=0, npc=pc_cur, clr_ifid=0.
- redir_pending=1 exactly while in PEND.
- stall_cnt increments on every clock with pc_en=0 (including HALT) and saturates at all-ones.
- No alignment or range check is done on any target; the PC register flags AdEL.
- pc_cur changes only on clk after pc_en=1. The block must have no combinational loop from pc_cur to pc_en except the halt compare.

Test Plan:
- Reset release with pc_cur=0x3000, no stall -> npc=0x3004, pc_en=1, clr_ifid=0; while reset=0 -> npc=0x3000, pc_en=0, clr_ifid=1.
- br_taken=1, br_target=0x3040, stall=1 for 3 cycles then 0 -> pc_en=0 and redir_pending=1 for 3 cycles; next cycle npc=0x3040, pc_en=1; stall_cnt=3.
- PEND holding 0x3040 and exc_entry=1 with stall=1 -> npc=0x4180, pc_en=1, clr_ifid=1; next cycle redir_pending=0, state RUN.
- eret=1, epc=30'h0000_0C05 -> npc=0x3014, pc_en=1, clr_ifid=1; with exc_entry also 1 -> npc=0x4180.
- pc_cur=0x417C, no events -> halted=1 next cycle, pc_en=0 thereafter; exc_entry pulse -> npc=0x4180, halted=0.
- Assert reset=0 mid-PEND (asynchronously, between edges) -> redir_pending=0 and pc_en=0 immediately; stall_cnt=0.
